// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave endpoint.
//   - SPI mode bit positions (CPOL / CPHA inside the 2-bit mode number)
//   - byte width and the default byte returned when nothing was loaded
//   - interface state encoding
package spi_pkg;

  localparam int CPOL_BIT = 1;  // SCK idle level
  localparam int CPHA_BIT = 0;  // 0: sample on leading edge, 1: on trailing edge
  localparam int BYTE_W   = 8;
  localparam int CNT_W    = $clog2(BYTE_W);

  localparam logic [BYTE_W-1:0] DEFAULT_IDLE_BYTE = 8'hFF;

  typedef enum logic {
    ST_IDLE,    // chip select high
    ST_ACTIVE   // chip select low
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, followed by one history
// flop used to detect transitions of the synchronised value.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset, all flops load RST_VAL
//   din  : asynchronous input
//   sync : synchronised level
//   rise : one-cycle pulse on a 0->1 transition of sync
//   fall : one-cycle pulse on a 1->0 transition of sync
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= RST_VAL;
      sync_q <= RST_VAL;
      prev   <= RST_VAL;
    end else begin
      meta   <= din;
      sync_q <= meta;
      prev   <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev;
  assign fall = ~sync_q & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint, clocked by the local system clock. SCK, CS_n and MOSI
// are oversampled through synchronisers; MOSI is deserialised into bytes and
// a preloaded TX byte is serialised onto MISO, MSB first, in any SPI mode.
// Ports:
//   i_clk, i_rst          : system clock, asynchronous active-high reset
//   i_TX_Byte, i_TX_DV    : byte to return to the master and its load strobe
//   o_TX_Ready            : holding register empty
//   o_TX_Underrun         : pulse, a byte slot started with nothing loaded
//   o_RX_DV, o_RX_Byte    : pulse and value of each completed received byte
//   i_SPI_clk, i_SPI_CS_n, i_SPI_MOSI : board-level SPI inputs (asynchronous)
//   o_SPI_MISO, o_SPI_MISO_En         : serial data out and its output enable
module spi_slave
  import spi_pkg::*;
#(
  parameter int                SPI_MODE     = 0,
  parameter logic [BYTE_W-1:0] TX_IDLE_BYTE = DEFAULT_IDLE_BYTE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_TX_Byte,
  input  logic              i_TX_DV,
  output logic              o_TX_Ready,
  output logic              o_TX_Underrun,
  output logic              o_RX_DV,
  output logic [BYTE_W-1:0] o_RX_Byte,
  input  logic              i_SPI_clk,
  input  logic              i_SPI_CS_n,
  input  logic              i_SPI_MOSI,
  output logic              o_SPI_MISO,
  output logic              o_SPI_MISO_En
);

  localparam logic [1:0] MODE = SPI_MODE[1:0];
  localparam logic       CPOL = MODE[CPOL_BIT];
  localparam logic       CPHA = MODE[CPHA_BIT];

  // ---------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------
  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_meta, mosi_sync;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sck_sync (
    .clk  (i_clk),
    .rst  (i_rst),
    .din  (i_SPI_clk),
    .sync (sck_sync),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk  (i_clk),
    .rst  (i_rst),
    .din  (i_SPI_CS_n),
    .sync (cs_sync),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= i_SPI_MOSI;
      mosi_sync <= mosi_meta;
    end
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  state_t state_reg, state_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (cs_fall) state_next = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Edge classification. An edge is leading when SCK has just left its
  // idle level, trailing when it has just returned to it.
  // ---------------------------------------------------------------------
  logic sck_edge, lead_edge, trail_edge;
  logic active, sample_edge, shift_edge;
  logic [CNT_W-1:0] bit_cnt;
  logic last_bit, slot_start;

  assign sck_edge    = sck_rise | sck_fall;
  assign lead_edge   = sck_edge & (sck_sync != CPOL);
  assign trail_edge  = sck_edge & (sck_sync == CPOL);
  assign active      = (state_reg == ST_ACTIVE) & ~cs_sync;
  assign sample_edge = active & (CPHA ? trail_edge : lead_edge);
  assign shift_edge  = active & (CPHA ? lead_edge : trail_edge);
  assign last_bit    = (bit_cnt == CNT_W'(BYTE_W - 1));

  // A new byte slot opens at CS_n fall and at every 8th sample edge, so the
  // next MSB is already on MISO for back-to-back bytes.
  assign slot_start  = ((state_reg == ST_IDLE) & cs_fall) | (sample_edge & last_bit);

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  logic [BYTE_W-1:0] hold_byte;
  logic              hold_full;
  logic [BYTE_W-1:0] tx_shift;
  logic [BYTE_W-1:0] rx_shift;
  logic [BYTE_W-1:0] rx_next;

  assign rx_next = {rx_shift[BYTE_W-2:0], mosi_sync};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_byte     <= '0;
      hold_full     <= 1'b0;
      tx_shift      <= '1;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      o_RX_Byte     <= '0;
      o_RX_DV       <= 1'b0;
      o_TX_Underrun <= 1'b0;
    end else begin
      o_RX_DV       <= 1'b0;
      o_TX_Underrun <= 1'b0;

      // Receive side; a CS_n rise throws away any partial byte.
      if ((state_reg == ST_ACTIVE) && cs_rise) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + CNT_W'(1);
        if (last_bit) begin
          o_RX_Byte <= rx_next;
          o_RX_DV   <= 1'b1;
        end
      end

      // Transmit side. The first shift edge of a slot (bit_cnt == 0) keeps
      // the MSB in place: for CPHA=0 it is the trailing edge right after the
      // slot was reloaded, for CPHA=1 it is the edge that launches the MSB.
      if ((state_reg == ST_ACTIVE) && cs_rise) begin
        tx_shift <= '1;
      end else if (slot_start) begin
        tx_shift      <= hold_full ? hold_byte : TX_IDLE_BYTE;
        o_TX_Underrun <= ~hold_full;
      end else if (shift_edge && (bit_cnt != '0)) begin
        tx_shift <= {tx_shift[BYTE_W-2:0], 1'b1};
      end

      // Holding register: a slot start empties it; a load is accepted only
      // while it is empty, so a load coinciding with an empty slot start is
      // kept for the following slot.
      if (slot_start && hold_full) begin
        hold_full <= 1'b0;
      end else if (i_TX_DV && !hold_full) begin
        hold_byte <= i_TX_Byte;
        hold_full <= 1'b1;
      end
    end
  end

  assign o_TX_Ready    = ~hold_full;
  assign o_SPI_MISO_En = (state_reg == ST_ACTIVE);
  assign o_SPI_MISO    = (state_reg == ST_ACTIVE) ? tx_shift[BYTE_W-1] : 1'b1;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave. One slave per SPI mode shares SCK/MOSI; each
// has its own chip select, so only the addressed slave takes part.
// A behavioural master drives SCK with a half period of 4 system clocks.
// Because a new slot opens at every 8th sample edge, each transfer also loads
// a filler byte once the slot has begun, so that trailing slot never underruns.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic [3:0] tx_dv = 4'h0;
  logic [3:0] tx_ready, underrun, rx_dv, miso, miso_en;
  logic [7:0] rx_byte [4];
  logic       sck = 1'b0;
  logic [3:0] cs_n = 4'hF;
  logic       mosi = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_cnt [4] = '{0, 0, 0, 0};
  int ur_cnt [4] = '{0, 0, 0, 0};
  logic [7:0] hist0 = 8'h00, hist1 = 8'h00;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    spi_slave #(.SPI_MODE(gi)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_TX_Byte    (tx_byte),
      .i_TX_DV      (tx_dv[gi]),
      .o_TX_Ready   (tx_ready[gi]),
      .o_TX_Underrun(underrun[gi]),
      .o_RX_DV      (rx_dv[gi]),
      .o_RX_Byte    (rx_byte[gi]),
      .i_SPI_clk    (sck),
      .i_SPI_CS_n   (cs_n[gi]),
      .i_SPI_MOSI   (mosi),
      .o_SPI_MISO   (miso[gi]),
      .o_SPI_MISO_En(miso_en[gi])
    );
  end

  // Pulse counters and mode-0 receive history
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_dv[i])    dv_cnt[i] <= dv_cnt[i] + 1;
      if (underrun[i]) ur_cnt[i] <= ur_cnt[i] + 1;
    end
    if (rx_dv[0]) begin
      hist1 <= hist0;
      hist0 <= rx_byte[0];
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic load(input int m, input logic [7:0] b);
    @(negedge clk);
    tx_byte  = b;
    tx_dv[m] = 1'b1;
    @(negedge clk);
    tx_dv[m] = 1'b0;
  endtask

  task automatic cs_low(input int m);
    logic [1:0] md;
    md = m[1:0];
    @(negedge clk);
    sck = md[1];
    repeat (4) @(negedge clk);
    cs_n[m] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high(input int m);
    repeat (4) @(negedge clk);
    cs_n[m] = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_byte(input int m, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    logic [1:0] md;
    logic       cpol, cpha;
    md   = m[1:0];
    cpol = md[1];
    cpha = md[0];
    rx   = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = tx[7-i];
        half();
        rx  = {rx[6:0], miso[m]};
        sck = ~cpol;
        half();
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = tx[7-i];
        half();
        rx  = {rx[6:0], miso[m]};
        sck = cpol;
        half();
      end
    end
    if (!cpha) half();
  endtask

  task automatic mode_xfer(input int m, input string tag);
    logic [7:0] r;
    int dv0, ur0;
    load(m, 8'h3C);
    check({tag, " ready after load"}, 32'(tx_ready[m]), 32'h0);
    dv0 = dv_cnt[m];
    ur0 = ur_cnt[m];
    cs_low(m);
    check({tag, " miso_en active"}, 32'(miso_en[m]), 32'h1);
    load(m, 8'h00);
    spi_byte(m, 8'hC1, 8, r);
    cs_high(m);
    check({tag, " master rx"}, 32'(r), 32'h3C);
    check({tag, " slave rx"}, 32'(rx_byte[m]), 32'hC1);
    check({tag, " dv pulses"}, 32'(dv_cnt[m] - dv0), 32'h1);
    check({tag, " underruns"}, 32'(ur_cnt[m] - ur0), 32'h0);
    check({tag, " miso_en idle"}, 32'(miso_en[m]), 32'h0);
  endtask

  initial begin
    logic [7:0] r1, r2;
    int dv0, ur0;

    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("reset m%0d ready", m), 32'(tx_ready[m]), 32'h1);
      check($sformatf("reset m%0d miso", m), 32'(miso[m]), 32'h1);
      check($sformatf("reset m%0d miso_en", m), 32'(miso_en[m]), 32'h0);
      check($sformatf("reset m%0d rx_byte", m), 32'(rx_byte[m]), 32'h0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte in every mode
    for (int m = 0; m < 4; m++) mode_xfer(m, $sformatf("mode%0d", m));

    // Back-to-back bytes under one CS_n low (mode 0)
    dv0 = dv_cnt[0];
    ur0 = ur_cnt[0];
    load(0, 8'h12);
    cs_low(0);
    for (int i = 0; i < 20 && !tx_ready[0]; i++) @(negedge clk);
    check("b2b ready after slot start", 32'(tx_ready[0]), 32'h1);
    load(0, 8'h34);
    spi_byte(0, 8'hBE, 8, r1);
    check("b2b ready after 2nd slot", 32'(tx_ready[0]), 32'h1);
    load(0, 8'h00);
    spi_byte(0, 8'hEF, 8, r2);
    cs_high(0);
    check("b2b master rx 1", 32'(r1), 32'h12);
    check("b2b master rx 2", 32'(r2), 32'h34);
    check("b2b slave rx 1", 32'(hist1), 32'hBE);
    check("b2b slave rx 2", 32'(hist0), 32'hEF);
    check("b2b dv pulses", 32'(dv_cnt[0] - dv0), 32'h2);
    check("b2b underruns", 32'(ur_cnt[0] - ur0), 32'h0);

    // Underrun: nothing loaded when CS_n falls
    dv0 = dv_cnt[0];
    ur0 = ur_cnt[0];
    cs_low(0);
    check("underrun pulses at cs fall", 32'(ur_cnt[0] - ur0), 32'h1);
    load(0, 8'h00);
    spi_byte(0, 8'hA5, 8, r1);
    cs_high(0);
    check("underrun master rx", 32'(r1), 32'hFF);
    check("underrun total pulses", 32'(ur_cnt[0] - ur0), 32'h1);
    check("underrun slave rx", 32'(rx_byte[0]), 32'hA5);
    check("underrun dv pulses", 32'(dv_cnt[0] - dv0), 32'h1);

    // Abort after 5 SCK cycles, then a full byte
    dv0 = dv_cnt[0];
    cs_low(0);
    spi_byte(0, 8'hFF, 5, r1);
    cs_high(0);
    check("abort no dv", 32'(dv_cnt[0] - dv0), 32'h0);
    check("abort rx_byte unchanged", 32'(rx_byte[0]), 32'hA5);
    cs_low(0);
    load(0, 8'h00);
    spi_byte(0, 8'h5A, 8, r1);
    cs_high(0);
    check("after abort slave rx", 32'(rx_byte[0]), 32'h5A);
    check("after abort dv pulses", 32'(dv_cnt[0] - dv0), 32'h1);

    // Reset in the middle of a byte
    load(0, 8'h77);
    cs_low(0);
    spi_byte(0, 8'h0F, 4, r1);
    check("pre-reset miso_en", 32'(miso_en[0]), 32'h1);
    check("pre-reset ready", 32'(tx_ready[0]), 32'h1);
    load(0, 8'h66);
    check("pre-reset ready held", 32'(tx_ready[0]), 32'h0);
    rst = 1'b1;
    #1;
    check("mid reset ready", 32'(tx_ready[0]), 32'h1);
    check("mid reset underrun", 32'(underrun[0]), 32'h0);
    check("mid reset rx_dv", 32'(rx_dv[0]), 32'h0);
    check("mid reset rx_byte", 32'(rx_byte[0]), 32'h0);
    check("mid reset miso", 32'(miso[0]), 32'h1);
    check("mid reset miso_en", 32'(miso_en[0]), 32'h0);
    cs_n[0] = 1'b1;
    sck     = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    mode_xfer(0, "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
